gpio_pwm_capture: RTL and testbench
===================================

Name: gpio_pwm_capture

Overview:
- Measures high time and low time of a GPIO pin driven by an external PWM source; the receive-side counterpart of the GPIO PWM generator.
- Results use the same 12-bit hout/lout, 2-bit ctrl and 3-bit prescale encodings as the generator, so software can read back a generator's waveform directly through a loopback.
- Sits beside the GPIO pin mux; results go to the local register bank.

Parameters:
- SYNC_STAGES, 2, number of input synchronizer flops on pwm_in (minimum 2).

Ports:
- clk  input  1  system clock (100 MHz; prescale table assumes 10 ns).
- reset_n  input  1  asynchronous, active-low reset.
- pwm_in  input  1  asynchronous pin input.
- cap_ctrl  input  2  0 = disabled; 1 = one-shot; 2 = continuous; 3 = reserved, behaves as 0.
- cap_prescale  input  3  tick divisor N, same table as the generator: 0 = no ticks (disabled), 1 = 1, 2 = 10, 3 = 100, 4 = 1e3, 5 = 1e4, 6 = 1e5, 7 = 1e6.
- cap_hout  output  12  last measured high time, in ticks.
- cap_lout  output  12  last measured low time, in ticks.
- cap_valid  output  1  one-clock pulse when cap_hout and cap_lout update.
- cap_busy  output  1  high while armed or measuring.
- cap_ovf  output  1  sticky; a count saturated.

Behaviour:
- Reset (reset_n=0, asynchronous): all outputs 0, FSM in IDLE, all counters 0, synchronizer flops 0.
- Input path:
  - cap_ctrl and cap_prescale are registered once (ctrl_p1, prescale_p1).
  - pwm_in passes through SYNC_STAGES flops, then one history flop.
  - Rise = sync & ~hist; fall = ~sync & hist.
  - Edge detect latency: SYNC_STAGES+1 clocks after the pin transition.
- Prescaler:
  - Stop value = N-1.
  - A tick occurs on each cycle where the prescale counter equals stop; the counter then wraps to 0.
  - The prescale counter resets on every detected edge, so the edge cycle is tick position 0.
  - N=1 ticks every cycle, including the edge cycle.
  - Prescale counter is 20 bits.
- Measured value: floor(L/N), where L is the level duration in clocks in the synchronized domain.
  - Counts are 12 bits and saturate at 4095.
  - On saturation, set cap_ovf.
- FSM states and transitions:
  - IDLE: busy=0. Go to ARM when ctrl_p1 is 1 or 2 and prescale_p1 != 0.
  - ARM: busy=1. Ignore any partial pulse. On rise, clear the high counter and go to MEAS_H.
  - MEAS_H: count ticks. On fall, store the high count internally, clear the low counter and go to MEAS_L.
  - MEAS_L: count ticks. On rise:
    - Load cap_hout and cap_lout together on the clock after the rise; cap_valid=1 for that single cycle.
    - ctrl=2: go to MEAS_H; this rise also starts the next high phase, with no lost cycles.
    - ctrl=1: go to DONE.
  - DONE: busy=0. Hold results. Go to IDLE when ctrl_p1 is 0 or 3.
- Abort rules:
  - Any change of ctrl_p1 or prescale_p1 outside IDLE/DONE discards the measurement in progress.
  - The FSM returns to IDLE (re-arms next cycle if still enabled); cap_hout/cap_lout keep their old values; no cap_valid.
- cap_ovf is cleared only when ctrl_p1 is 0 or 3, or on reset.
- A saturated measurement still completes and pulses cap_valid with the value 4095.
- A fall in ARM is ignored.
- Pulses shorter than one clock after synchronization may be missed; no requirement applies to them.
- cap_hout/cap_lout hold their values through disable; only reset clears them.

Test Plan:
- prescale=1, ctrl=2; pin high 5 clk / low 3 clk repeating -> first cap_valid after the first full high+low; hout=5, lout=3; cap_valid every 8 clk thereafter; cap_ovf=0.
- prescale=2 (N=10), ctrl=1; pin high 25 clk, low 47 clk -> one cap_valid with hout=2, lout=4; busy falls; later pulses cause no further cap_valid.
- Arm (ctrl 0→2) while pin already high for 3 clk, then 6 high / 4 low -> partial pulse ignored; first result hout=6, lout=4.
- prescale=1; pin high 5000 clk, low 10 clk -> hout=4095, lout=10, cap_ovf=1; ovf stays 1 through later normal results; ctrl=0 clears it.
- Mid-MEAS_L, change prescale 1→3 -> no cap_valid; old outputs held; next full period measured in 1 µs ticks (high 300 clk → hout=3).
- reset_n asserted mid-MEAS_H -> all outputs 0 immediately (asynchronous); after release with ctrl=2, waits for a fresh rise before measuring.

Source files
------------

// File: rtl/gpio_pwm_capture_if.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pwm_capture_if
// Description : Pin, control and result bundle for the GPIO PWM capture block.
// Revision    : 1.0 - initial release
// ============================================================================
interface gpio_pwm_capture_if;
    logic        pwm_in;
    logic [1:0]  cap_ctrl;
    logic [2:0]  cap_prescale;
    logic [11:0] cap_hout;
    logic [11:0] cap_lout;
    logic        cap_valid;
    logic        cap_busy;
    logic        cap_ovf;

    modport master (
        output pwm_in, cap_ctrl, cap_prescale,
        input  cap_hout, cap_lout, cap_valid, cap_busy, cap_ovf
    );

    modport slave (
        input  pwm_in, cap_ctrl, cap_prescale,
        output cap_hout, cap_lout, cap_valid, cap_busy, cap_ovf
    );
endinterface
`default_nettype wire

// File: rtl/gpio_pwm_capture.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pwm_capture
// Description : Measures high and low time of an external PWM pin in prescaled
//               ticks, using the same hout/lout/ctrl/prescale encodings as the
//               GPIO PWM generator.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_pwm_capture #(
    parameter int SYNC_STAGES = 2
) (
    input wire                 clk,
    input wire                 reset_n,
    gpio_pwm_capture_if.slave  bus
);

    localparam int PRIME_MAX = SYNC_STAGES + 1;
    localparam int PRIME_W   = $clog2(SYNC_STAGES + 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_MEAS_H = 3'd2,
        S_MEAS_L = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             ctrl_p1_q, ctrl_p1_d, ctrl_p2_q, ctrl_p2_d;
    logic [2:0]             prescale_p1_q, prescale_p1_d, prescale_p2_q, prescale_p2_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic [PRIME_W-1:0]     prime_q, prime_d;
    logic [19:0]            pcnt_q, pcnt_d;
    logic [11:0]            hcnt_q, hcnt_d, lcnt_q, lcnt_d, hstore_q, hstore_d;
    logic [11:0]            hout_q, hout_d, lout_q, lout_d;
    logic                   valid_q, valid_d, busy_q, busy_d, ovf_q, ovf_d;

    logic        sync, primed, rise, fall, tick, abort, enabled, set_ovf;
    logic [19:0] n_div, pcnt_eff;

    always_comb begin
        ctrl_p1_d     = bus.cap_ctrl;
        ctrl_p2_d     = ctrl_p1_q;
        prescale_p1_d = bus.cap_prescale;
        prescale_p2_d = prescale_p1_q;
        sync_d        = {sync_q[SYNC_STAGES-2:0], bus.pwm_in};
        sync          = sync_q[SYNC_STAGES-1];
        hist_d        = sync;

        // Edges are suppressed until the synchronizer and history flop hold
        // real pin samples, so a pin already high at reset release is not a rise.
        primed  = (prime_q == PRIME_W'(PRIME_MAX));
        prime_d = primed ? prime_q : prime_q + PRIME_W'(1);
        rise    = primed & sync & ~hist_q;
        fall    = primed & ~sync & hist_q;

        case (prescale_p1_q)
            3'd1:    n_div = 20'd1;
            3'd2:    n_div = 20'd10;
            3'd3:    n_div = 20'd100;
            3'd4:    n_div = 20'd1000;
            3'd5:    n_div = 20'd10000;
            3'd6:    n_div = 20'd100000;
            3'd7:    n_div = 20'd1000000;
            default: n_div = 20'd0;
        endcase

        pcnt_eff = (rise | fall) ? 20'd0 : pcnt_q;
        tick     = (n_div != 20'd0) && (pcnt_eff == n_div - 20'd1);

        abort   = (ctrl_p1_q != ctrl_p2_q) || (prescale_p1_q != prescale_p2_q);
        enabled = ((ctrl_p1_q == 2'd1) || (ctrl_p1_q == 2'd2)) && (prescale_p1_q != 3'd0);

        state_d  = state_q;
        hcnt_d   = hcnt_q;
        lcnt_d   = lcnt_q;
        hstore_d = hstore_q;
        hout_d   = hout_q;
        lout_d   = lout_q;
        valid_d  = 1'b0;
        set_ovf  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enabled) state_d = S_ARM;
            end
            S_ARM: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (rise) begin
                    hcnt_d  = {11'd0, tick};
                    state_d = S_MEAS_H;
                end
            end
            S_MEAS_H: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (fall) begin
                    hstore_d = hcnt_q;
                    lcnt_d   = {11'd0, tick};
                    state_d  = S_MEAS_L;
                end else if (tick) begin
                    if (hcnt_q == 12'hFFF) set_ovf = 1'b1;
                    else                   hcnt_d  = hcnt_q + 12'd1;
                end
            end
            S_MEAS_L: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (rise) begin
                    hout_d  = hstore_q;
                    lout_d  = lcnt_q;
                    valid_d = 1'b1;
                    // In continuous mode this rise is tick position 0 of the next high phase.
                    if (ctrl_p1_q == 2'd2) begin
                        hcnt_d  = {11'd0, tick};
                        state_d = S_MEAS_H;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (tick) begin
                    if (lcnt_q == 12'hFFF) set_ovf = 1'b1;
                    else                   lcnt_d  = lcnt_q + 12'd1;
                end
            end
            S_DONE: begin
                if ((ctrl_p1_q == 2'd0) || (ctrl_p1_q == 2'd3)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if ((state_q == S_IDLE) || (state_q == S_DONE)) pcnt_d = 20'd0;
        else                                            pcnt_d = tick ? 20'd0 : pcnt_eff + 20'd1;

        busy_d = (state_d == S_ARM) || (state_d == S_MEAS_H) || (state_d == S_MEAS_L);
        ovf_d  = ((ctrl_p1_q == 2'd0) || (ctrl_p1_q == 2'd3)) ? 1'b0 : (ovf_q | set_ovf);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            ctrl_p1_q     <= 2'd0;
            ctrl_p2_q     <= 2'd0;
            prescale_p1_q <= 3'd0;
            prescale_p2_q <= 3'd0;
            sync_q        <= '0;
            hist_q        <= 1'b0;
            prime_q       <= '0;
            pcnt_q        <= 20'd0;
            hcnt_q        <= 12'd0;
            lcnt_q        <= 12'd0;
            hstore_q      <= 12'd0;
            hout_q        <= 12'd0;
            lout_q        <= 12'd0;
            valid_q       <= 1'b0;
            busy_q        <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            ctrl_p1_q     <= ctrl_p1_d;
            ctrl_p2_q     <= ctrl_p2_d;
            prescale_p1_q <= prescale_p1_d;
            prescale_p2_q <= prescale_p2_d;
            sync_q        <= sync_d;
            hist_q        <= hist_d;
            prime_q       <= prime_d;
            pcnt_q        <= pcnt_d;
            hcnt_q        <= hcnt_d;
            lcnt_q        <= lcnt_d;
            hstore_q      <= hstore_d;
            hout_q        <= hout_d;
            lout_q        <= lout_d;
            valid_q       <= valid_d;
            busy_q        <= busy_d;
            ovf_q         <= ovf_d;
        end
    end

    assign bus.cap_hout  = hout_q;
    assign bus.cap_lout  = lout_q;
    assign bus.cap_valid = valid_q;
    assign bus.cap_busy  = busy_q;
    assign bus.cap_ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_pwm_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_pwm_capture
// Description : Self-checking bench for gpio_pwm_capture.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_pwm_capture;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    gpio_pwm_capture_if bus();

    gpio_pwm_capture #(.SYNC_STAGES(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct { int h; int l; bit ovf; } res_t;
    typedef struct { int ctrl; int pre; int high; int low; int npulse; int exp_h; int exp_l; } vec_t;

    res_t exp_q[$];
    int   vtimes[$];
    vec_t vecs[5];
    int   checks    = 0;
    int   errors    = 0;
    int   valid_cnt = 0;
    int   cyc       = 0;
    bit   model_ovf = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every cap_valid must match the oldest expected result.
    always @(negedge clk) begin
        res_t e;
        if (reset_n && bus.cap_valid) begin
            valid_cnt++;
            vtimes.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got hout=%0d lout=%0d, required no cap_valid",
                         bus.cap_hout, bus.cap_lout);
            end else begin
                e = exp_q.pop_front();
                if (bus.cap_hout != 12'(e.h) || bus.cap_lout != 12'(e.l) || bus.cap_ovf != e.ovf) begin
                    errors++;
                    $display("FAIL result: got hout=%0d lout=%0d ovf=%0d, required hout=%0d lout=%0d ovf=%0d",
                             bus.cap_hout, bus.cap_lout, bus.cap_ovf, e.h, e.l, e.ovf);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int h, input int l);
        bus.pwm_in = 1'b1;
        wait_clk(h);
        bus.pwm_in = 1'b0;
        wait_clk(l);
    endtask

    task automatic set_ctrl(input int c);
        bus.cap_ctrl = 2'(c);
        if (c == 0 || c == 3) model_ovf = 1'b0;
    endtask

    function automatic int n_of(input int pre);
        case (pre)
            1: return 1;
            2: return 10;
            3: return 100;
            4: return 1000;
            5: return 10000;
            6: return 100000;
            7: return 1000000;
            default: return 0;
        endcase
    endfunction

    // Reference: result = floor(duration / N), saturating at 4095 with sticky overflow.
    task automatic push_exp(input int h, input int l, input int n);
        int eh, el;
        eh = h / n;
        el = l / n;
        if (eh > 4095 || el > 4095) model_ovf = 1'b1;
        if (eh > 4095) eh = 4095;
        if (el > 4095) el = 4095;
        exp_q.push_back('{eh, el, model_ovf});
    endtask

    task automatic go_idle();
        set_ctrl(0);
        wait_clk(3);
        bus.pwm_in = 1'b0;
        wait_clk(6);
    endtask

    initial begin
        int base, pre, n, h, l;
        bus.pwm_in       = 1'b0;
        bus.cap_ctrl     = 2'd0;
        bus.cap_prescale = 3'd0;

        vecs[0] = '{2, 1,   5,   3, 4,  5, 3};
        vecs[1] = '{1, 2,  25,  47, 3,  2, 4};
        vecs[2] = '{2, 2, 100,   9, 3, 10, 0};
        vecs[3] = '{2, 3, 250, 120, 2,  2, 1};
        vecs[4] = '{1, 1,   7,   2, 2,  7, 2};

        #12;
        chk("reset_hout",  bus.cap_hout,  0);
        chk("reset_lout",  bus.cap_lout,  0);
        chk("reset_valid", bus.cap_valid, 0);
        chk("reset_busy",  bus.cap_busy,  0);
        chk("reset_ovf",   bus.cap_ovf,   0);
        reset_n = 1'b1;
        wait_clk(5);

        foreach (vecs[k]) begin
            set_ctrl(vecs[k].ctrl);
            bus.cap_prescale = 3'(vecs[k].pre);
            wait_clk(5);
            base = valid_cnt;
            vtimes.delete();
            for (int i = 0; i < vecs[k].npulse; i++) begin
                if (vecs[k].ctrl == 2 || i == 0)
                    exp_q.push_back('{vecs[k].exp_h, vecs[k].exp_l, 1'b0});
                pulse(vecs[k].high, vecs[k].low);
            end
            bus.pwm_in = 1'b1;
            wait_clk(8);
            chk("vec_valid_count", valid_cnt - base, (vecs[k].ctrl == 2) ? vecs[k].npulse : 1);
            chk("vec_busy", bus.cap_busy, (vecs[k].ctrl == 2) ? 1 : 0);
            chk("vec_ovf", bus.cap_ovf, 0);
            if (k == 0)
                for (int i = 1; i < vtimes.size(); i++)
                    chk("valid_spacing", vtimes[i] - vtimes[i-1], 8);
            go_idle();
        end

        // Randomized continuous captures against the reference model.
        for (int r = 0; r < 3; r++) begin
            pre = $urandom_range(1, 2);
            n   = n_of(pre);
            set_ctrl(2);
            bus.cap_prescale = 3'(pre);
            wait_clk(5);
            base = valid_cnt;
            for (int i = 0; i < 12; i++) begin
                h = $urandom_range(1, (n == 1) ? 30 : 60);
                l = $urandom_range(1, (n == 1) ? 30 : 60);
                push_exp(h, l, n);
                pulse(h, l);
            end
            bus.pwm_in = 1'b1;
            wait_clk(8);
            chk("rand_valid_count", valid_cnt - base, 12);
            go_idle();
        end

        // Arm while the pin is already high: the partial pulse is ignored.
        bus.cap_prescale = 3'd1;
        bus.pwm_in = 1'b1;
        wait_clk(3);
        set_ctrl(2);
        wait_clk(3);
        bus.pwm_in = 1'b0;
        wait_clk(5);
        base = valid_cnt;
        push_exp(6, 4, 1);
        pulse(6, 4);
        bus.pwm_in = 1'b1;
        wait_clk(8);
        chk("arm_high_valid_count", valid_cnt - base, 1);
        go_idle();

        // Saturation: sticky overflow survives later results, cleared by disable.
        set_ctrl(2);
        bus.cap_prescale = 3'd1;
        wait_clk(5);
        base = valid_cnt;
        push_exp(5000, 10, 1);
        pulse(5000, 10);
        push_exp(5, 3, 1);
        pulse(5, 3);
        bus.pwm_in = 1'b1;
        wait_clk(8);
        chk("ovf_valid_count", valid_cnt - base, 2);
        chk("ovf_sticky", bus.cap_ovf, 1);
        set_ctrl(0);
        wait_clk(4);
        chk("ovf_cleared", bus.cap_ovf, 0);
        chk("hout_held_disabled", bus.cap_hout, 5);
        bus.pwm_in = 1'b0;
        wait_clk(6);

        // Prescale change mid low phase aborts the measurement in progress.
        set_ctrl(2);
        bus.cap_prescale = 3'd1;
        wait_clk(5);
        base = valid_cnt;
        push_exp(5, 3, 1);
        pulse(5, 3);
        bus.pwm_in = 1'b1;
        wait_clk(4);
        bus.pwm_in = 1'b0;
        wait_clk(3);
        bus.cap_prescale = 3'd3;
        wait_clk(20);
        chk("abort_valid_count", valid_cnt - base, 1);
        chk("abort_hout_held", bus.cap_hout, 5);
        chk("abort_lout_held", bus.cap_lout, 3);
        push_exp(300, 200, 100);
        pulse(300, 200);
        bus.pwm_in = 1'b1;
        wait_clk(8);
        chk("abort_next_count", valid_cnt - base, 2);
        go_idle();

        // Asynchronous reset in the middle of a high phase.
        set_ctrl(2);
        bus.cap_prescale = 3'd1;
        wait_clk(5);
        push_exp(5, 3, 1);
        pulse(5, 3);
        bus.pwm_in = 1'b1;
        wait_clk(10);
        chk("pre_reset_busy", bus.cap_busy, 1);
        reset_n = 1'b0;
        #1;
        chk("async_hout",  bus.cap_hout,  0);
        chk("async_lout",  bus.cap_lout,  0);
        chk("async_busy",  bus.cap_busy,  0);
        chk("async_valid", bus.cap_valid, 0);
        wait_clk(3);
        reset_n = 1'b1;
        wait_clk(5);
        bus.pwm_in = 1'b0;
        wait_clk(5);
        base = valid_cnt;
        push_exp(6, 3, 1);
        pulse(6, 3);
        bus.pwm_in = 1'b1;
        wait_clk(8);
        chk("post_reset_valid_count", valid_cnt - base, 1);
        go_idle();

        chk("expected_left", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
